// File: rtl/soc_mem_pkg.sv
// Shared data-memory map constants and arbiter state encoding.
package soc_mem_pkg;

  localparam int unsigned PADDR_W = 11;

  localparam logic [31:0] GP_BASE  = 32'h1001_0000;
  localparam logic [31:0] GP_LIMIT = 32'h1001_0FFF;
  localparam logic [31:0] SP_BASE  = 32'h7FFF_F000;
  localparam logic [31:0] SP_LIMIT = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arbState_t;

endpackage

// File: rtl/dmem_addr_decode.sv
// Virtual byte address to physical word address decode for the data RAM.
module dmem_addr_decode
  import soc_mem_pkg::*;
(
  input  logic [31:0] addr,
  output logic [10:0] phys,
  output logic        invalid
);

  // Global window maps to the low half, stack window to the high half.
  always_comb begin
    phys    = '0;
    invalid = 1'b1;
    if (addr >= GP_BASE && addr <= GP_LIMIT) begin
      phys    = addr[12:2];
      invalid = (addr[1:0] != 2'b00);
    end else if (addr >= SP_BASE && addr <= SP_LIMIT) begin
      phys    = {1'b1, addr[11:2]};
      invalid = (addr[1:0] != 2'b00);
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU
// load/store unit (r0) and the debug/loader port (r1).
module dmem_access_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned PADDR_W = soc_mem_pkg::PADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               r0_req,
  input  logic               r0_we,
  input  logic [31:0]        r0_addr,
  input  logic [31:0]        r0_wdata,
  output logic               r0_gnt,
  output logic               r0_rvalid,
  output logic [31:0]        r0_rdata,
  output logic               r0_fault,
  input  logic               r1_req,
  input  logic               r1_we,
  input  logic [31:0]        r1_addr,
  input  logic [31:0]        r1_wdata,
  output logic               r1_gnt,
  output logic               r1_rvalid,
  output logic [31:0]        r1_rdata,
  output logic               r1_fault,
  output logic               mem_en,
  output logic               mem_we,
  output logic [PADDR_W-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic [7:0]         fault_cnt
);

  import soc_mem_pkg::*;

  arbState_t   state, nextState;
  logic        ptr;
  logic        sel;
  logic        lWe;
  logic        lFault;
  logic [1:0]  waitCnt;

  logic        anyReq;
  logic        pickSel;
  logic        pickWe;
  logic [31:0] pickAddr;
  logic [31:0] pickWdata;
  logic [10:0] decPhys;
  logic        decInvalid;
  logic        waitLast;
  logic        toResp;
  logic [31:0] respData;

  dmem_addr_decode uDecode (
    .addr    (pickAddr),
    .phys    (decPhys),
    .invalid (decInvalid)
  );

  // Requester selection: pointer breaks ties, otherwise whoever is asking.
  always_comb begin
    anyReq    = r0_req | r1_req;
    pickSel   = (r0_req && r1_req) ? ptr : r1_req;
    pickWe    = pickSel ? r1_we    : r0_we;
    pickAddr  = pickSel ? r1_addr  : r0_addr;
    pickWdata = pickSel ? r1_wdata : r0_wdata;
    waitLast  = (state == WAIT) && (waitCnt == 2'(MEM_LAT - 1));
    toResp    = ((state == ISSUE) && lFault) || waitLast;
    respData  = (lWe || lFault) ? '0 : mem_rdata;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ISSUE;
      ISSUE:   nextState = lFault ? RESP : WAIT;
      WAIT:    if (waitLast) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register, transaction latch, wait counter and fairness pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      sel     <= 1'b0;
      lWe     <= 1'b0;
      lFault  <= 1'b0;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && anyReq) begin
        sel    <= pickSel;
        lWe    <= pickWe;
        lFault <= decInvalid;
      end
      waitCnt <= (state == WAIT) ? waitCnt + 2'd1 : '0;
      if (state == RESP) ptr <= ~sel;
    end
  end

  // Registered outputs, loaded on the edge that enters ISSUE or RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      r0_fault  <= 1'b0;
      r1_fault  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      fault_cnt <= '0;
    end else begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      r0_fault  <= 1'b0;
      r1_fault  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if (state == IDLE && anyReq) begin
        r0_gnt    <= ~pickSel;
        r1_gnt    <= pickSel;
        mem_en    <= ~decInvalid;
        mem_we    <= pickWe & ~decInvalid;
        mem_addr  <= decInvalid ? '0 : PADDR_W'(decPhys);
        mem_wdata <= decInvalid ? '0 : pickWdata;
      end
      if (toResp) begin
        if (sel) begin
          r1_rvalid <= 1'b1;
          r1_fault  <= lFault;
          r1_rdata  <= respData;
        end else begin
          r0_rvalid <= 1'b1;
          r0_fault  <= lFault;
          r0_rdata  <= respData;
        end
        if (lFault && fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Scoreboard bench for dmem_access_arbiter with a transaction-level memory model.
module tb_dmem_access_arbiter;

  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 1'b0, r0_we = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0;
  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r1_addr = '0, r1_wdata = '0;
  logic        r0_gnt, r0_rvalid, r0_fault, r1_gnt, r1_rvalid, r1_fault;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_en, mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [7:0]  fault_cnt;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          who;
    logic [31:0] rdata;
    logic        fault;
    int unsigned due;
  } rsp_t;

  req_t        pend [2];
  rsp_t        rspQ [$];
  int          grantLog [$];
  logic [31:0] modelMem [int unsigned];
  int unsigned faultModel = 0;

  dmem_access_arbiter #(.MEM_LAT(LAT), .PADDR_W(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_fault(r0_fault),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_fault(r1_fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Contents of a never-written RAM word.
  function automatic logic [31:0] seed(input int unsigned a);
    if (a == 1) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // RAM model: synchronous write, read data MEM_LAT cycles after mem_en.
  logic [31:0] ram [0:2047];
  logic        written [0:2047];
  logic [31:0] rdPipe [0:LAT-1];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    rdPipe[0] <= (mem_en && !mem_we) ? (written[mem_addr] === 1'b1 ? ram[mem_addr] : seed(32'(mem_addr)))
                                     : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign mem_rdata = rdPipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory map written out as plain address arithmetic.
  function automatic void refDecode(input logic [31:0] a, output bit ok, output int unsigned phys);
    ok = 1'b0;
    phys = 0;
    if (a % 4 != 0) return;
    if (a >= 32'h1001_0000 && a < 32'h1001_1000) begin
      ok = 1'b1;
      phys = (a - 32'h1001_0000) / 4;
    end else if (a >= 32'h7FFF_F000 && a <= 32'h7FFF_FFFF) begin
      ok = 1'b1;
      phys = 1024 + (a - 32'h7FFF_F000) / 4;
    end
  endfunction

  // Monitor: checks memory-side behaviour at grant, pops the scoreboard at rvalid.
  always @(negedge clk) begin
    bit          ok;
    int unsigned phys;
    int          n;
    rsp_t        r;
    if (rst_n) begin
      if (r0_gnt || r1_gnt) begin
        chk("gnt_onehot", 32'(r0_gnt & r1_gnt), 32'd0);
        n = r1_gnt ? 1 : 0;
        grantLog.push_back(n);
        refDecode(pend[n].addr, ok, phys);
        chk("issue_mem_en", 32'(mem_en), 32'(ok));
        if (ok) begin
          chk("issue_mem_addr", 32'(mem_addr), phys);
          chk("issue_mem_we", 32'(mem_we), 32'(pend[n].we));
          if (pend[n].we) chk("issue_mem_wdata", mem_wdata, pend[n].wdata);
        end else begin
          chk("fault_mem_we", 32'(mem_we), 32'd0);
        end
        r.who   = n;
        r.fault = !ok;
        r.due   = cyc + (ok ? 1 + LAT : 1);
        r.rdata = '0;
        if (ok && pend[n].we) modelMem[phys] = pend[n].wdata;
        else if (ok) r.rdata = modelMem.exists(phys) ? modelMem[phys] : seed(phys);
        if (!ok) faultModel++;
        rspQ.push_back(r);
      end
      if (r0_rvalid || r1_rvalid) begin
        chk("rvalid_onehot", 32'(r0_rvalid & r1_rvalid), 32'd0);
        chk("resp_mem_en", {30'd0, mem_en, mem_we}, 32'd0);
        chk("resp_mem_wdata", mem_wdata, 32'd0);
        if (rspQ.size() == 0) begin
          chk("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          r = rspQ.pop_front();
          chk("resp_who", 32'(r1_rvalid), 32'(r.who));
          chk("resp_rdata", r1_rvalid ? r1_rdata : r0_rdata, r.rdata);
          chk("resp_fault", 32'(r1_rvalid ? r1_fault : r0_fault), 32'(r.fault));
          chk("resp_cycle", cyc, r.due);
        end
      end
    end
  end

  task automatic issue(input int n, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold, input int expWait);
    int waited = 0;
    bit got = 0;
    pend[n] = '{we: we, addr: addr, wdata: wdata};
    if (n == 0) begin r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1; end
    else        begin r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1; end
    while (!got && waited < 200) begin
      @(negedge clk);
      waited++;
      got = (n == 0) ? r0_gnt : r1_gnt;
    end
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
    if (expWait > 0) chk("gnt_latency", 32'(waited), 32'(expWait));
    #2;
    if (!hold) begin
      if (n == 0) r0_req = 1'b0; else r1_req = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (rspQ.size() != 0 && k < 500) begin @(negedge clk); k++; end
    if (rspQ.size() != 0) begin
      chk("drain_timeout", 32'(rspQ.size()), 32'd0);
      rspQ.delete();
    end
    @(negedge clk);
    #2;
  endtask

  task automatic chkAllZero(input string name);
    chk({name, "_ctl"}, {24'd0, r0_gnt, r0_rvalid, r0_fault, r1_gnt, r1_rvalid, r1_fault, mem_en, mem_we}, 32'd0);
    chk({name, "_rdata"}, r0_rdata | r1_rdata, 32'd0);
    chk({name, "_maddr"}, 32'(mem_addr), 32'd0);
    chk({name, "_mwdata"}, mem_wdata, 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rspQ.delete();
    grantLog.delete();
    faultModel = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 5))
      0: return 32'h1001_0000 + ($urandom_range(0, 15) << 2);
      1: return 32'h7FFF_FFC0 + ($urandom_range(0, 15) << 2);
      2: return 32'h1001_0000 + $urandom_range(0, 4095);
      3: return $urandom();
      4: return 32'h7FFF_F000 + ($urandom_range(0, 1023) << 2);
      default: return 32'h1001_0FFC;
    endcase
  endfunction

  task automatic randTraffic(input int n, input int count);
    for (int i = 0; i < count; i++) begin
      issue(n, 1'($urandom_range(0, 1)), randAddr(), $urandom(), 1'b0, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      #2;
    end
  endtask

  initial begin
    logic [31:0] badAddr [4];
    badAddr[0] = 32'h1001_1000;
    badAddr[1] = 32'h1000_FFFC;
    badAddr[2] = 32'h8000_0000;
    badAddr[3] = 32'h1001_0002;

    #1;
    chkAllZero("reset");
    chk("reset_fault_cnt", 32'(fault_cnt), 32'd0);
    doReset();

    // Directed accesses: first read, write then read-back, window edges.
    issue(0, 1'b0, 32'h1001_0004, 32'h0, 1'b0, 1);
    drain();
    issue(1, 1'b1, 32'h7FFF_FFFC, 32'hCAFE_F00D, 1'b0, 1);
    drain();
    issue(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 1'b0, 1);
    drain();
    issue(0, 1'b0, 32'h1001_0FFC, 32'h0, 1'b0, 1);
    drain();
    issue(1, 1'b0, 32'h7FFF_F000, 32'h0, 1'b0, 1);
    drain();
    for (int i = 0; i < 4; i++) begin
      issue(i % 2, 1'(i / 2), badAddr[i], 32'h1234_5678, 1'b0, 1);
      drain();
    end
    chk("fault_cnt_directed", 32'(fault_cnt), faultModel);

    // Both requesters held high: grants must alternate starting with r0.
    doReset();
    fork
      begin
        issue(0, 1'b0, 32'h1001_0020, 32'h0, 1'b1, 0);
        issue(0, 1'b1, 32'h1001_0024, 32'h1111_2222, 1'b0, 0);
      end
      begin
        issue(1, 1'b1, 32'h7FFF_FF00, 32'h3333_4444, 1'b1, 0);
        issue(1, 1'b0, 32'h1001_0024, 32'h0, 1'b0, 0);
      end
    join
    drain();
    chk("fair_count", 32'(grantLog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grantLog.size()) chk("fair_order", 32'(grantLog[i]), 32'(i % 2));
    end

    // Concurrent randomized traffic.
    fork
      randTraffic(0, 30);
      randTraffic(1, 30);
    join
    drain();
    chk("fault_cnt_random", 32'(fault_cnt), (faultModel > 255) ? 32'd255 : faultModel);

    // Reset asserted while the read waits on the RAM.
    issue(0, 1'b0, 32'h1001_0010, 32'h0, 1'b0, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chkAllZero("midreset");
    chk("midreset_fault_cnt", 32'(fault_cnt), 32'd0);
    rspQ.delete();
    faultModel = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    issue(0, 1'b0, 32'h1001_0010, 32'h0, 1'b0, 1);
    drain();

    // Saturation of the fault counter.
    for (int i = 0; i < 300; i++) begin
      issue(i % 2, 1'b0, badAddr[i % 4], 32'h0, 1'b0, 0);
      if (i == 100) begin
        drain();
        chk("fault_cnt_mid", 32'(fault_cnt), faultModel);
      end
    end
    drain();
    chk("fault_cnt_sat", 32'(fault_cnt), 32'd255);
    chk("fault_model_total", faultModel, 32'd300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_access_arbiter.md
Name: dmem_access_arbiter

Overview:
- Shares the single-port 2048-word data memory between two requesters: requester 0 is the CPU load/store unit, requester 1 is the debug/loader port.
- Arbitrates requests round-robin and decodes 32-bit virtual byte addresses to 11-bit physical word addresses.
- Sequences the memory access, returns the read data or a fault, and counts faults.
- Sits between the pipeline MEM stage/debug bridge and the data RAM.

Parameters:
- MEM_LAT, 1, read latency of the data RAM in cycles (1..3).
- PADDR_W, 11, physical word address width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rN_req  in  1  request from requester N (N=0,1); held with its operands stable until rN_gnt.
- rN_we  in  1  1 = write, 0 = read.
- rN_addr  in  32  virtual byte address.
- rN_wdata  in  32  write data.
- rN_gnt  out  1  one-cycle pulse: request accepted; requester may drop or change req.
- rN_rvalid  out  1  one-cycle pulse: transaction complete.
- rN_rdata  out  32  read data, valid with rvalid; 0 for writes and faults.
- rN_fault  out  1  pulses with rvalid when the address is invalid.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  PADDR_W  physical word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid MEM_LAT cycles after mem_en.
- fault_cnt  out  8  saturating fault counter.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE; priority pointer favours r0.
  - All outputs 0, fault_cnt = 0.
  - An in-flight transaction is dropped; the requester must re-issue it.
- Address decode:
  - Global window 0x10010000..0x10010FFF maps to phys = addr[12:2], giving 0..1023.
  - Stack window 0x7FFFF000..0x7FFFFFFF maps to phys = 1024 + addr[11:2], giving 1024..2047.
  - Any other address is invalid.
  - addr[1:0] != 0 is also invalid.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
  - IDLE: if any req is high, select a requester.
    - If both are high, the pointer decides.
    - Latch we/addr/wdata and the decode result, then go to ISSUE.
  - ISSUE (1 cycle): pulse gnt to the selected requester.
    - Valid address: mem_en = 1; mem_we = we; drive mem_addr/mem_wdata. Go to WAIT.
    - Invalid address: mem_en = mem_we = 0. Go to RESP with fault flagged.
  - WAIT: count MEM_LAT cycles, capturing mem_rdata on the final count, then go to RESP.
  - RESP (1 cycle): pulse rvalid to the selected requester.
    - rdata = captured data for a read; 0 for a write or fault.
    - fault as latched.
    - Pointer moves to favour the other requester. Go to IDLE.
- Latency:
  - Valid access: req seen at cycle t gives gnt at t+1 and rvalid at t+2+MEM_LAT.
  - Fault: rvalid at t+2.
- Dropped requests: req dropping before the capture in IDLE is ignored. Once captured, the transaction always completes.
- Idle outputs: the non-selected requester's gnt/rvalid/fault stay 0. mem_en, mem_we and mem_wdata are 0 outside ISSUE.
- fault_cnt:
  - Increments in the RESP cycle of each faulted transaction.
  - Saturates at 255.
  - Clears only on reset.
- Fairness: under continuous requests from both, grants alternate 0, 1, 0, 1.

Decomposition:
- Package soc_mem_pkg holds:
  - window base/limit constants (GP_BASE, GP_LIMIT, SP_BASE, SP_LIMIT);
  - PADDR_W;
  - the FSM state enum.
- Sub-module dmem_addr_decode (combinational): in addr[31:0]; out phys[10:0], invalid.

Test Plan:
- Reset then r0 read at 0x10010004, mem_rdata = 0xDEADBEEF, MEM_LAT = 1 → mem_addr = 1 in ISSUE; r0_gnt at t+1; r0_rvalid at t+3 with rdata 0xDEADBEEF, fault = 0.
- r1 write 0xCAFEF00D to 0x7FFFFFFC → mem_en = mem_we = 1, mem_addr = 2047, mem_wdata = 0xCAFEF00D; r1_rvalid with rdata = 0.
- Boundary addresses:
  - 0x10010FFC maps to 1023; 0x7FFFF000 maps to 1024.
  - 0x10011000, 0x1000FFFC, 0x80000000 and 0x10010002 each give fault = 1 at t+2 with mem_en never high.
- Both requesters held high for 4 transactions → grant order 0, 1, 0, 1; no simultaneous gnt or rvalid.
- rst_n pulled low during WAIT → all outputs 0 immediately, no rvalid; the re-issued request completes normally.
- 300 invalid requests → fault_cnt reads 255, with no wrap.
